// File: rtl/riscv_pkg.sv
// Shared core definitions: next-PC select encodings, the canonical NOP and the fetch state enum.
package riscv_pkg;

    localparam logic [1:0]  PCSRC_SEQ    = 2'b00;
    localparam logic [1:0]  PCSRC_TARGET = 2'b01;
    localparam logic [1:0]  PCSRC_ALU    = 2'b10;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_HOLD = 3'd3,
        FS_DROP = 3'd4
    } fetch_state_t;

    // 2'b11 is reserved and behaves as sequential
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return (pcsrc == PCSRC_TARGET) || (pcsrc == PCSRC_ALU);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and memory.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; an invalid entry always reads as NOP.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'h0;
            pc_plus4_d <= 32'h0;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (!stall && load) begin
            instr_d    <= instr;
            pc_d       <= pc;
            pc_plus4_d <= pc + 32'd4;
            valid_d    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem handshake, stall hold buffer and redirect squash.
//  state | meaning
//  IDLE  | post-reset, no request
//  REQ   | request driven at PCF, waiting for gnt
//  WAIT  | granted, waiting for the response
//  HOLD  | response parked in hold buffer while decode stalls
//  DROP  | redirected with a response still in flight; discard it
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         PCSrcE,
    input  logic [31:0]        PCTargetE,
    input  logic [31:0]        ALUResultE,
    input  logic               StallD,
    input  logic               FlushD,
    fetch_unit_if.master       imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD
);

    fetch_state_t state;
    logic [31:0]  pcf;
    logic [31:0]  hold_data;
    logic         hold_valid;
    logic         req_q;
    logic         redirect;
    logic [31:0]  target;
    logic         load;
    logic [31:0]  load_instr;

    assign redirect  = is_redirect(PCSrcE);
    assign target    = (PCSrcE == PCSRC_TARGET) ? PCTargetE : (ALUResultE & ~32'h1);
    assign imem.req  = req_q;
    assign imem.addr = {pcf[31:2], 2'b00};

    always_comb begin
        load       = 1'b0;
        load_instr = imem.rdata;
        if (!redirect && !StallD) begin
            if (state == FS_WAIT && imem.rvalid) begin
                load = 1'b1;
            end else if (state == FS_HOLD && hold_valid) begin
                load       = 1'b1;
                load_instr = hold_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FS_IDLE;
            pcf        <= RESET_PC;
            hold_data  <= 32'h0;
            hold_valid <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            if (redirect) pcf <= target;
            case (state)
                FS_IDLE: begin
                    state <= FS_REQ;
                    req_q <= 1'b1;
                end
                FS_REQ: begin
                    if (imem.gnt) begin
                        state <= redirect ? FS_DROP : FS_WAIT;
                        req_q <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (redirect) begin
                        state <= imem.rvalid ? FS_REQ : FS_DROP;
                        req_q <= imem.rvalid;
                    end else if (imem.rvalid) begin
                        if (!StallD) begin
                            pcf   <= pcf + 32'd4;
                            state <= FS_REQ;
                            req_q <= 1'b1;
                        end else begin
                            hold_data  <= imem.rdata;
                            hold_valid <= 1'b1;
                            state      <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (redirect || !StallD) begin
                        if (!redirect) pcf <= pcf + 32'd4;
                        hold_valid <= 1'b0;
                        state      <= FS_REQ;
                        req_q      <= 1'b1;
                    end
                end
                FS_DROP: begin
                    if (imem.rvalid) begin
                        state <= FS_REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= FS_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Only one request may be outstanding, so a response with none in flight is a memory bug
    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem.rvalid && (state == FS_IDLE || state == FS_REQ)));

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (FlushD),
        .stall      (StallD),
        .load       (load),
        .instr      (load_instr),
        .pc         (pcf),
        .instr_d    (InstrD),
        .pc_d       (PCD),
        .pc_plus4_d (PCPlus4D),
        .valid_d    (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding instruction memory model.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    logic        gnt_en;
    logic        rsp_en;
    logic        outstanding;
    logic [31:0] pend_addr;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem       (imem.master),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    assign imem.gnt    = imem.req && gnt_en;
    assign imem.rvalid = outstanding && rsp_en;
    assign imem.rdata  = imem.rvalid ? mem_word(pend_addr) : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
            pend_addr   <= 32'h0;
        end else begin
            if (imem.rvalid) outstanding <= 1'b0;
            if (imem.req && imem.gnt) begin
                outstanding <= 1'b1;
                pend_addr   <= imem.addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
        PCSrcE = PCSRC_SEQ; PCTargetE = 32'h0; ALUResultE = 32'h0;
        StallD = 1'b0; FlushD = 1'b0;
        step(); step();
        check("rst_req",    {31'h0, imem.req}, 32'h0);
        check("rst_valid",  {31'h0, ValidD},   32'h0);
        check("rst_instr",  InstrD,            NOP_INSTR);
        check("rst_pcd",    PCD,               32'h0);
        check("rst_pcp4",   PCPlus4D,          32'h0);
        rst_n = 1'b1;

        step();  // IDLE -> REQ
        check("first_req",  {31'h0, imem.req}, 32'h1);
        check("first_addr", imem.addr,         32'h0);
        step();  // granted, WAIT
        check("wait_noreq", {31'h0, imem.req}, 32'h0);
        step();  // word@0 loaded
        check("i0_instr",   InstrD,            mem_word(32'h0));
        check("i0_pcd",     PCD,               32'h0);
        check("i0_pcp4",    PCPlus4D,          32'h4);
        check("i0_valid",   {31'h0, ValidD},   32'h1);
        check("addr4",      imem.addr,         32'h4);
        step(); step();  // word@4 loaded
        check("i4_pcd",     PCD,               32'h4);
        check("i4_instr",   InstrD,            mem_word(32'h4));
        check("addr8",      imem.addr,         32'h8);

        step();  // WAIT for addr 8; response arrives next edge under stall
        StallD = 1'b1;
        step();
        check("hold_noreq", {31'h0, imem.req}, 32'h0);
        check("hold_instr", InstrD,            mem_word(32'h4));
        step(); step();
        check("hold3_req",  {31'h0, imem.req}, 32'h0);
        check("hold3_pcd",  PCD,               32'h4);
        StallD = 1'b0;
        step();
        check("rel_instr",  InstrD,            mem_word(32'h8));
        check("rel_pcd",    PCD,               32'h8);
        check("rel_addr",   imem.addr,         32'hC);
        check("rel_req",    {31'h0, imem.req}, 32'h1);

        step(); step();  // word@C loaded, request for 0x10 pending
        check("iC_pcd",     PCD,               32'hC);
        rsp_en = 1'b0;
        step();  // WAIT for 0x10 with response withheld
        PCSrcE = PCSRC_TARGET; PCTargetE = 32'h100; FlushD = 1'b1;
        step();  // -> DROP
        PCSrcE = PCSRC_SEQ; FlushD = 1'b0;
        check("drop_valid", {31'h0, ValidD},   32'h0);
        check("drop_instr", InstrD,            NOP_INSTR);
        check("drop_noreq", {31'h0, imem.req}, 32'h0);
        step();
        check("drop2_req",  {31'h0, imem.req}, 32'h0);
        rsp_en = 1'b1;
        step();  // late response discarded
        check("br_addr",    imem.addr,         32'h100);
        check("br_req",     {31'h0, imem.req}, 32'h1);
        check("br_valid",   {31'h0, ValidD},   32'h0);
        step(); step();
        check("br_pcd",     PCD,               32'h100);
        check("br_instr",   InstrD,            mem_word(32'h100));
        check("br_valid2",  {31'h0, ValidD},   32'h1);

        step();  // WAIT for 0x104, response this cycle
        PCSrcE = PCSRC_ALU; ALUResultE = 32'h203; FlushD = 1'b1;
        step();
        PCSrcE = PCSRC_SEQ; FlushD = 1'b0;
        check("jalr_addr",  imem.addr,         32'h200);
        check("jalr_req",   {31'h0, imem.req}, 32'h1);
        check("jalr_valid", {31'h0, ValidD},   32'h0);
        check("jalr_instr", InstrD,            NOP_INSTR);
        step(); step();
        check("jalr_pcd",   PCD,               32'h202);
        check("jalr_pcp4",  PCPlus4D,          32'h206);
        check("jalr_word",  InstrD,            mem_word(32'h200));

        step();  // WAIT for 0x204
        rst_n = 1'b0;
        step();
        check("mid_rst_req",   {31'h0, imem.req}, 32'h0);
        check("mid_rst_valid", {31'h0, ValidD},   32'h0);
        check("mid_rst_instr", InstrD,            NOP_INSTR);
        check("mid_rst_pcd",   PCD,               32'h0);
        check("mid_rst_pcp4",  PCPlus4D,          32'h0);
        check("mid_rst_addr",  imem.addr,         32'h0);
        rst_n = 1'b1; gnt_en = 1'b0;
        step();
        check("re_req",     {31'h0, imem.req}, 32'h1);
        check("re_addr",    imem.addr,         32'h0);
        PCSrcE = PCSRC_TARGET; PCTargetE = 32'hFFFF_FFFC; FlushD = 1'b1;
        step();  // redirect while ungranted in REQ
        PCSrcE = PCSRC_SEQ; FlushD = 1'b0; gnt_en = 1'b1;
        check("top_addr",   imem.addr,         32'hFFFF_FFFC);
        check("top_req",    {31'h0, imem.req}, 32'h1);
        step(); step();
        check("wrap_pcd",   PCD,               32'hFFFF_FFFC);
        check("wrap_pcp4",  PCPlus4D,          32'h0);
        check("wrap_addr",  imem.addr,         32'h0);
        check("wrap_instr", InstrD,            mem_word(32'hFFFF_FFFC));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
